imem_responder: RTL
===================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The parameter DEPTH_WORDS SHALL default to 256 and set the instruction storage size in 32-bit words (power of two).
REQ-002 The parameter BASE_ADDR SHALL default to 32'h0000_0000 and set the byte address of word 0.
REQ-003 The parameter WAIT_STATES SHALL default to 0 (range 0..15) and set the extra response latency in cycles.
REQ-004 The port clk SHALL be an input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 The port res SHALL be an input, 1 bit, with synchronous active-high reset.
REQ-006 The port imem_req SHALL be an input, 1 bit, the fetch request from the fetch stage.
REQ-007 The port imem_addr SHALL be an input, 32 bits, the byte address of the fetch.
REQ-008 The port imem_data SHALL be an output, 32 bits, the returned instruction word.
REQ-009 The port imem_ready SHALL be an output, 1 bit, meaning imem_data and imem_fault are valid this cycle.
REQ-010 The port imem_fault SHALL be an output, 1 bit, meaning the access was misaligned or out of range.
REQ-011 The port load_we SHALL be an input, 1 bit, the program-load write enable.
REQ-012 The port load_addr SHALL be an input, 32 bits, the program-load byte address.
REQ-013 The port load_data SHALL be an input, 32 bits, the program-load write data.

Function
REQ-014 A write SHALL occur at the rising edge when load_we=1 and load_addr is aligned and in range; otherwise the write SHALL be silently dropped.
REQ-015 The module SHALL treat an access as in range when (addr - BASE_ADDR) < DEPTH_WORDS*4, using unsigned 32-bit arithmetic so that addresses below BASE wrap out of range.
REQ-016 The module SHALL treat an access as faulting when addr[1:0] != 0 or the access is out of range; a faulting access SHALL return imem_data = 32'h0000_0013 (NOP) with imem_fault=1.
REQ-017 When WAIT_STATES=0, the path SHALL be purely combinational: imem_ready = imem_req, imem_data = word[imem_addr] the same cycle, and imem_fault per REQ-016 gated by imem_req.
REQ-018 When WAIT_STATES>0, the module SHALL use an FSM with states IDLE, WAIT and RESP.
REQ-019 In IDLE with imem_req=1, the module SHALL latch imem_addr, load the counter with WAIT_STATES-1, and go to WAIT.
REQ-020 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the cycle after the counter reads 0.
REQ-021 In RESP, the module SHALL assert imem_ready=1 for exactly one cycle with data read from the latched address at that cycle, then return to IDLE.
REQ-022 The request-to-ready latency SHALL be WAIT_STATES+1 cycles after the accepting edge, and a new request SHALL be accepted no earlier than the edge after RESP.
REQ-023 Changes on imem_addr or imem_req during WAIT/RESP SHALL be ignored, so a transaction is never aborted by the requester.
REQ-024 A load write to the latched address during WAIT SHALL be visible in RESP, and a write in the RESP cycle itself SHALL NOT affect that cycle's imem_data (read-before-write).
REQ-025 Outside RESP (WAIT_STATES>0), or when imem_req=0 (WAIT_STATES=0), imem_ready and imem_fault SHALL be 0 and imem_data SHALL be 32'h0000_0013.

Reset
REQ-026 While res=1, the FSM SHALL be IDLE, the counter 0, the latched address BASE_ADDR, and imem_ready=0, imem_fault=0, imem_data=32'h0000_0013 (WAIT_STATES>0).
REQ-027 Reset asserted mid-transaction SHALL drop the transaction with no imem_ready pulse.
REQ-028 Storage contents SHALL NOT be cleared by reset.
REQ-029 Load writes SHALL be honoured during reset.

Structure
REQ-030 The NOP constant 32'h0000_0013 and the FSM state enum (IDLE, WAIT, RESP) SHALL reside in the shared package riscv_pkg.
REQ-031 Storage SHALL be one sub-module, imem_array: DEPTH_WORDS x 32, one synchronous write port and one asynchronous read port, word-indexed.
REQ-032 Range, alignment and FSM logic SHALL reside in imem_responder.

Verification
REQ-033 The bench SHALL cover: WAIT_STATES=0, load 0x00500093 at 0x0, req=1 addr=0x0 -> same-cycle ready=1, data=0x00500093, fault=0.
REQ-034 The bench SHALL cover: WAIT_STATES=3, req at edge N with addr=0x4 holding 0x00A00113 -> ready=1 only in cycle N+4, data=0x00A00113, and no acceptance at N+4.
REQ-035 The bench SHALL cover: addr=0x2, and addr=BASE+DEPTH_WORDS*4=0x400 -> ready with fault=1, data=0x00000013; a load write to 0x400 is dropped.
REQ-036 The bench SHALL cover: WAIT_STATES=2, addr switched 0x8->0xC during WAIT, and load_we writing 0xDEADBEEF to 0x8 in WAIT -> RESP returns 0xDEADBEEF.
REQ-037 The bench SHALL cover: WAIT_STATES=3, res=1 for one cycle during WAIT -> no ready pulse, FSM in IDLE, earlier-loaded words still readable.
REQ-038 The bench SHALL cover: BASE_ADDR=0x8000_0000, addr=0x7FFF_FFFC -> fault=1 (wrap-around underflow).

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction-memory responder.
package riscv_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_array.sv
// Word-indexed instruction storage: one synchronous write port, one asynchronous read port.
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Program-load write; contents are never cleared
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder with range/alignment checking and optional wait states.
module imem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        res,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        imem_ready,
  output logic        imem_fault,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WS_M1 = 4'(WAIT_STATES - 1);

  // Addresses below BASE_ADDR wrap to large offsets and fall out of range
  function automatic logic is_fault(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] != 2'b00) || (off >= SPAN);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  logic [31:0] rd_addr;
  logic [31:0] rd_word;
  logic        rd_fault;
  logic        wr_en_c;

  assign rd_fault = is_fault(rd_addr);
  assign wr_en_c  = load_we && !is_fault(load_addr);

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (wr_en_c),
    .waddr(word_idx(load_addr)),
    .wdata(load_data),
    .raddr(word_idx(rd_addr)),
    .rdata(rd_word)
  );

  if (WAIT_STATES == 0) begin : g_comb
    // Zero-latency path: respond in the same cycle as the request
    assign rd_addr    = imem_addr;
    assign imem_ready = imem_req;
    assign imem_fault = imem_req && rd_fault;
    assign imem_data  = (imem_req && !rd_fault) ? rd_word : NOP_INSN;
  end else begin : g_fsm
    imem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;

    assign rd_addr = addr_q;

    // Next-state: latch on accept, count down, then sample storage in RESP
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = NOP_INSN;
      ready_d = 1'b0;
      fault_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (imem_req) begin
            addr_d  = imem_addr;
            cnt_d   = WS_M1;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d = RESP;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        RESP: begin
          // Read happens before any same-edge load write commits
          ready_d = 1'b1;
          fault_d = rd_fault;
          data_d  = rd_fault ? NOP_INSN : rd_word;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // State and registered outputs; reset drops any in-flight transaction
    always_ff @(posedge clk) begin
      if (res) begin
        state_q <= IDLE;
        cnt_q   <= 4'd0;
        addr_q  <= BASE_ADDR;
        data_q  <= NOP_INSN;
        ready_q <= 1'b0;
        fault_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        addr_q  <= addr_d;
        data_q  <= data_d;
        ready_q <= ready_d;
        fault_q <= fault_d;
      end
    end

    assign imem_ready = ready_q;
    assign imem_fault = fault_q;
    assign imem_data  = data_q;
  end

endmodule
